// File: rtl/fetch_pkg.sv
// Shared types and AXI constants for the instruction-fetch burst controller.
package fetch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_DRAIN} fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: clear beats push, push and pop in one cycle leave count unchanged.
module fetch_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // The controller only requests a burst when a whole burst fits.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(do_push && full));
endmodule

// File: rtl/fetch_burst_ctrl.sv
// Instruction fetch: aligned AXI read bursts fill a buffer that feeds decode; redirects flush it.
module fetch_burst_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                BURST_LEN  = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jal,
  input  logic [ADDR_W-1:0] jal_addr,
  input  logic              jalr_jcond,
  input  logic [ADDR_W-1:0] jalr_jcond_addr,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [1:0]        arburst,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0] fetch_pc
);
  localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~(BURST_BYTES - ADDR_W'(1));

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, araddr_q, araddr_d, beat_q, beat_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              redir_q, redir_d, armed_q;
  logic              redirect, push, pop, empty, has_space;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  count;

  assign arburst  = AXI_BURST_INCR;
  assign arsize   = AXI_SIZE_4B;
  assign arlen    = 8'(BURST_LEN - 1);
  assign arvalid  = arvalid_q;
  assign araddr   = araddr_q;
  assign rready   = rready_q;

  assign redirect  = jal || jalr_jcond;
  assign target    = (jalr_jcond ? jalr_jcond_addr : jal_addr) & ~ADDR_W'(3);
  assign has_space = (count <= CNT_W'(FIFO_DEPTH - BURST_LEN));
  assign pop       = fetch_valid && fetch_ready;
  assign fetch_valid = !empty;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    araddr_d  = araddr_q;
    beat_d    = beat_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    redir_d   = redir_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // armed_q holds off the first request for one cycle after reset.
        if (armed_q && has_space && !redirect) begin
          state_d   = ST_REQ;
          arvalid_d = 1'b1;
          araddr_d  = pc_q & ALIGN_MASK;
          redir_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (redirect) redir_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = araddr_q;
          state_d   = (redir_q || redirect) ? ST_DRAIN : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          beat_d = beat_q + ADDR_W'(4);
          push   = !redirect && (beat_q >= pc_q);
          if (rlast) begin
            state_d  = ST_IDLE;
            rready_d = 1'b0;
            pc_d     = araddr_q + BURST_BYTES;
          end
        end
        if (redirect && !(rvalid && rlast)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rvalid && rlast) begin
          state_d  = ST_IDLE;
          rready_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) pc_d = target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      araddr_q  <= '0;
      beat_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      redir_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      araddr_q  <= araddr_d;
      beat_q    <= beat_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      redir_q   <= redir_d;
      armed_q   <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W + ADDR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect),
    .push  (push),
    .wdata ({rdata, beat_q}),
    .pop   (pop),
    .rdata ({fetch_instr, fetch_pc}),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_burst_ctrl.sv
// Directed bench for fetch_burst_ctrl with hand-computed expectations.
module tb_fetch_burst_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jal = 1'b0, jalr_jcond = 1'b0;
  logic [31:0] jal_addr = '0, jalr_jcond_addr = '0;
  logic        arvalid, arready = 1'b1, rready, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] araddr, rdata = '0, fetch_instr, fetch_pc;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        fetch_valid, fetch_ready = 1'b0;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  fetch_burst_ctrl dut (
    .clk(clk), .rst(rst), .jal(jal), .jal_addr(jal_addr),
    .jalr_jcond(jalr_jcond), .jalr_jcond_addr(jalr_jcond_addr),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arburst(arburst), .arsize(arsize), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    rvalid = 1'b1; rdata = d; rlast = last;
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_fvalid", fetch_valid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_finstr", fetch_instr, 0);
    chk("rst_fpc", fetch_pc, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    step();
    chk("edge1_arvalid", arvalid, 0);
    step();
    chk("edge2_arvalid", arvalid, 1);
    chk("a_araddr", araddr, 32'h0);
    chk("a_arlen", arlen, 3);
    chk("a_arburst", arburst, 1);
    chk("a_arsize", arsize, 2);
    chk("a_rready_req", rready, 0);
    step();
    chk("a_arvalid_done", arvalid, 0);
    chk("a_rready_data", rready, 1);
    beat(32'h13, 0);
    chk("a_fvalid", fetch_valid, 1);
    chk("a_head_instr", fetch_instr, 32'h13);
    beat(32'h93, 0);
    beat(32'h113, 0);
    beat(32'h193, 1);
    chk("a_rready_idle", rready, 0);
    arready = 1'b0; fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("a_pop_pc", fetch_pc, 32'(4 * i));
      chk("a_pop_instr", fetch_instr, 32'h13 + 32'(i * 32'h80));
      step();
    end
    chk("a_empty", fetch_valid, 0);
    chk("a_next_araddr", araddr, 32'h10);
    fetch_ready = 1'b0;

    // two bursts with decode stalled: third request waits for space
    arready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) beat(32'hB010 + 32'(4 * i), i == 3);
    step();
    chk("b_arvalid2", arvalid, 1);
    chk("b_araddr2", araddr, 32'h20);
    step();
    for (int i = 0; i < 4; i++) beat(32'hB020 + 32'(4 * i), i == 3);
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_full_noreq", arvalid, 0);
    end
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b_pop_pc", fetch_pc, 32'h10 + 32'(4 * i));
      chk("b_pop_instr", fetch_instr, 32'hB010 + 32'(4 * i));
      step();
      chk("b_pop_noreq", arvalid, 0);
    end
    fetch_ready = 1'b0;
    step();
    chk("b_arvalid3", arvalid, 1);
    chk("b_araddr3", araddr, 32'h30);
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b_pop2_pc", fetch_pc, 32'h20 + 32'(4 * i));
      chk("b_pop2_instr", fetch_instr, 32'hB020 + 32'(4 * i));
      step();
    end
    fetch_ready = 1'b0;
    chk("b_empty", fetch_valid, 0);

    // redirect while the address phase is stalled
    jal = 1'b1; jal_addr = 32'h2004;
    step();
    jal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("e_arvalid_hold", arvalid, 1);
      chk("e_araddr_hold", araddr, 32'h30);
      if (i < 2) step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("e_drain_rready", rready, 1);
    for (int i = 0; i < 4; i++) begin
      beat(32'hDEAD0 + 32'(i), i == 3);
      chk("e_drain_drop", fetch_valid, 0);
    end
    chk("e_drain_done", rready, 0);
    step();
    chk("e_araddr", araddr, 32'h2000);
    arready = 1'b1;
    step();
    arready = 1'b0;
    beat(32'hE000, 0);
    chk("e_lead_drop", fetch_valid, 0);
    beat(32'hE004, 0);
    chk("e_first_pc", fetch_pc, 32'h2004);
    chk("e_first_instr", fetch_instr, 32'hE004);
    beat(32'hE008, 0);
    beat(32'hE00C, 1);
    fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("e_pop_pc", fetch_pc, 32'h2004 + 32'(4 * i));
      step();
    end
    fetch_ready = 1'b0;
    chk("e_next_araddr", araddr, 32'h2010);

    // jal during beat 2 of a burst
    arready = 1'b1;
    step();
    arready = 1'b0;
    beat(32'hC010, 0);
    chk("c_one_entry", fetch_valid, 1);
    jal = 1'b1; jal_addr = 32'h1008;
    beat(32'hC014, 0);
    jal = 1'b0;
    chk("c_flushed", fetch_valid, 0);
    beat(32'hC018, 0);
    chk("c_drop3", fetch_valid, 0);
    beat(32'hC01C, 1);
    chk("c_drop4", fetch_valid, 0);
    step();
    chk("c_araddr", araddr, 32'h1000);
    arready = 1'b1;
    step();
    arready = 1'b0;
    beat(32'hF000, 0);
    beat(32'hF004, 0);
    chk("c_lead_drop", fetch_valid, 0);
    beat(32'hF008, 0);
    chk("c_first_pc", fetch_pc, 32'h1008);
    chk("c_first_instr", fetch_instr, 32'hF008);
    beat(32'hF00C, 1);
    fetch_ready = 1'b1;
    step();
    chk("c_second_pc", fetch_pc, 32'h100C);
    step();
    fetch_ready = 1'b0;

    // simultaneous jal and jalr: jalr wins
    jal = 1'b1; jal_addr = 32'h200; jalr_jcond = 1'b1; jalr_jcond_addr = 32'h300;
    step();
    jal = 1'b0; jalr_jcond = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'h9000 + 32'(i), i == 3);
    step();
    chk("d_araddr", araddr, 32'h300);
    arready = 1'b1;
    step();
    arready = 1'b0;
    beat(32'h5300, 0);
    chk("d_first_pc", fetch_pc, 32'h300);
    chk("d_first_instr", fetch_instr, 32'h5300);
    beat(32'h5304, 0);

    // asynchronous reset in the middle of a burst
    rst = 1'b1;
    #1;
    chk("f_arvalid", arvalid, 0);
    chk("f_rready", rready, 0);
    chk("f_fvalid", fetch_valid, 0);
    chk("f_finstr", fetch_instr, 0);
    chk("f_fpc", fetch_pc, 0);
    chk("f_araddr", araddr, 0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("f_edge1", arvalid, 0);
    step();
    chk("f_edge2", arvalid, 1);
    chk("f_araddr_rst_pc", araddr, 32'h0);
    arready = 1'b1;
    step();
    beat(32'h77, 0);
    chk("f_first_pc", fetch_pc, 32'h0);
    chk("f_first_instr", fetch_instr, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
